// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit_id encodings and the input-channel FSM state type.
package noc_pkg;

  localparam logic [2:0] FLIT_NONE = 3'b000;
  localparam logic [2:0] FLIT_HDR  = 3'b001;
  localparam logic [2:0] FLIT_BODY = 3'b010;
  localparam logic [2:0] FLIT_TAIL = 3'b100;

  localparam int unsigned LEN_W = 12;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_GNT = 2'd1,
    ST_XFER     = 2'd2
  } ic_state_e;

endpackage

// File: rtl/flit_fifo.sv
// Synchronous flit FIFO with extra-MSB pointers; head entry is visible without a pop.
module flit_fifo #(
  parameter int unsigned WIDTH = 35,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]      wr_q, wr_d, rd_q, rd_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign empty_o = (wr_q == rd_q);
  // A push is refused while full even if the same cycle pops.
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign head_o  = mem_q[rd_q[AW-1:0]];

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (do_push) wr_d = wr_q + (AW+1)'(1);
    if (do_pop)  rd_d = rd_q + (AW+1)'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/input_channel.sv
// Router input channel: buffers link flits, requests the arbiter per packet and
// forwards granted flits to the crossbar; stray non-header flits are dropped in IDLE.
module input_channel
  import noc_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [2:0]        in_flit_id,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              req,
  output logic [2:0]        flit_id,
  output logic [LEN_W-1:0]  length,
  input  logic              grant,
  output logic              out_valid,
  output logic [2:0]        out_flit_id,
  output logic [DATA_W-1:0] out_data,
  output logic              drop
);

  localparam int unsigned FW = DATA_W + 3;

  logic [FW-1:0]     head;
  logic [2:0]        head_id;
  logic [DATA_W-1:0] head_data;
  logic              fifo_full, fifo_empty, pop, fwd;

  ic_state_e         state_q, state_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic              out_valid_q, drop_q, drop_d;
  logic [2:0]        out_id_q;
  logic [DATA_W-1:0] out_data_q;

  flit_fifo #(
    .WIDTH (FW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst),
    .push_i  (in_valid),
    .wdata_i ({in_flit_id, in_data}),
    .pop_i   (pop),
    .head_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign head_id   = head[FW-1:DATA_W];
  assign head_data = head[DATA_W-1:0];
  assign in_ready  = !fifo_full;
  assign flit_id   = fifo_empty ? FLIT_NONE : head_id;
  assign req       = (state_q != ST_IDLE);

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    pop     = 1'b0;
    fwd     = 1'b0;
    drop_d  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        // The header stays at the head; it is forwarded as the first flit of XFER.
        if (!fifo_empty) begin
          if (head_id == FLIT_HDR) begin
            len_d   = head_data[LEN_W-1:0];
            state_d = ST_WAIT_GNT;
          end else begin
            pop    = 1'b1;
            drop_d = 1'b1;
          end
        end
      end
      ST_WAIT_GNT: begin
        if (grant) state_d = ST_XFER;
      end
      ST_XFER: begin
        if (!grant) begin
          state_d = ST_WAIT_GNT;
        end else if (!fifo_empty) begin
          pop = 1'b1;
          fwd = 1'b1;
          if (head_id == FLIT_TAIL) state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      len_q       <= '0;
      out_valid_q <= 1'b0;
      out_id_q    <= '0;
      out_data_q  <= '0;
      drop_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      out_valid_q <= fwd;
      drop_q      <= drop_d;
      if (fwd) begin
        out_id_q   <= head_id;
        out_data_q <= head_data;
      end
    end
  end

  assign length      = len_q;
  assign out_valid   = out_valid_q;
  assign out_flit_id = out_id_q;
  assign out_data    = out_data_q;
  assign drop        = drop_q;

endmodule

// File: tb/tb_input_channel.sv
// Self-checking bench for input_channel: vector table plus scoreboard of forwarded flits.
module tb_input_channel;
  import noc_pkg::*;

  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic [2:0]    in_flit_id;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic          req;
  logic [2:0]    flit_id;
  logic [11:0]   length;
  logic          grant;
  logic          out_valid;
  logic [2:0]    out_flit_id;
  logic [DW-1:0] out_data;
  logic          drop;

  logic man_gnt;
  bit   auto_gnt;
  assign grant = auto_gnt ? req : man_gnt;

  always #5 clk = ~clk;

  input_channel #(
    .DATA_W (DW),
    .DEPTH  (DEPTH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_flit_id  (in_flit_id),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .req         (req),
    .flit_id     (flit_id),
    .length      (length),
    .grant       (grant),
    .out_valid   (out_valid),
    .out_flit_id (out_flit_id),
    .out_data    (out_data),
    .drop        (drop)
  );

  typedef struct {
    logic [2:0]  id;
    logic [31:0] data;
    logic [11:0] len;
  } exp_t;

  typedef struct {
    logic [2:0]  id;
    logic [31:0] data;
    bit          fwd;
    logic [11:0] len;
  } vec_t;

  exp_t sb[$];
  exp_t mon_e;
  vec_t vecs[13];
  int   total = 0;
  int   bad = 0;
  int   drops_seen = 0;
  int   exp_drops = 0;
  int   fwd_seen = 0;
  int   fwd_before;
  logic [31:0] d;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst && drop) drops_seen++;
    if (rst && out_valid) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_out: got id=%0h data=%0h required no output", out_flit_id, out_data);
      end else begin
        mon_e = sb.pop_front();
        fwd_seen++;
        chk("out_flit_id", 64'(out_flit_id), 64'(mon_e.id));
        chk("out_data", 64'(out_data), 64'(mon_e.data));
        chk("length", 64'(length), 64'(mon_e.len));
        chk("req_after_flit", 64'(req), 64'(mon_e.id == FLIT_TAIL ? 1'b0 : 1'b1));
      end
    end
  end

  task automatic push(input logic [2:0] id, input logic [31:0] data, input bit fwd, input logic [11:0] len);
    int unsigned n = 0;
    @(negedge clk);
    in_valid   = 1'b1;
    in_flit_id = id;
    in_data    = data;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      total++;
      bad++;
      $display("FAIL push_timeout: got in_ready=0 required 1 within 200 cycles");
      in_valid = 1'b0;
      return;
    end
    if (fwd) sb.push_back('{id, data, len});
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int unsigned n = 0;
    while (sb.size() != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL %s_drain: got %0d flits outstanding required 0", name, sb.size());
    end
    repeat (3) @(negedge clk);
    chk({name, "_req_idle"}, 64'(req), 64'(0));
    chk({name, "_fifo_empty"}, 64'(flit_id), 64'(FLIT_NONE));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no completion required finish before 100us");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;  in_valid = 1'b0;  in_flit_id = '0;  in_data = '0;
    man_gnt = 1'b0;  auto_gnt = 1'b0;

    #12;
    chk("rst_in_ready", 64'(in_ready), 64'(1));
    chk("rst_req", 64'(req), 64'(0));
    chk("rst_length", 64'(length), 64'(0));
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_out_flit_id", 64'(out_flit_id), 64'(0));
    chk("rst_out_data", 64'(out_data), 64'(0));
    chk("rst_drop", 64'(drop), 64'(0));
    chk("rst_flit_id", 64'(flit_id), 64'(0));
    @(negedge clk);
    rst = 1'b1;

    // Basic packet: req rises one cycle after the header reaches the head.
    push(FLIT_HDR, 32'hABC0_000A, 1'b1, 12'h00A);
    @(negedge clk);
    chk("hdr_at_head", 64'(flit_id), 64'(FLIT_HDR));
    chk("req_not_yet", 64'(req), 64'(0));
    @(negedge clk);
    chk("req_rise", 64'(req), 64'(1));
    chk("len_latched", 64'(length), 64'(12'h00A));
    auto_gnt = 1'b1;
    push(FLIT_BODY, 32'h1234_5678, 1'b1, 12'h00A);
    push(FLIT_TAIL, 32'h8765_4321, 1'b1, 12'h00A);
    drain("basic");

    // Vector table: strays, illegal codes, mid-packet header.
    vecs[0]  = '{FLIT_BODY, 32'h1111_0001, 1'b0, 12'h000};
    vecs[1]  = '{FLIT_HDR,  32'h5555_0005, 1'b1, 12'h005};
    vecs[2]  = '{FLIT_TAIL, 32'h7777_0002, 1'b1, 12'h005};
    vecs[3]  = '{3'b011,    32'h0303_0303, 1'b0, 12'h000};
    vecs[4]  = '{3'b000,    32'h0404_0404, 1'b0, 12'h000};
    vecs[5]  = '{FLIT_TAIL, 32'h0505_0505, 1'b0, 12'h000};
    vecs[6]  = '{FLIT_HDR,  32'hCAFE_0007, 1'b1, 12'h007};
    vecs[7]  = '{FLIT_HDR,  32'h0000_0123, 1'b1, 12'h007};
    vecs[8]  = '{FLIT_BODY, 32'hDEAD_BEEF, 1'b1, 12'h007};
    vecs[9]  = '{FLIT_TAIL, 32'hFEED_F00D, 1'b1, 12'h007};
    vecs[10] = '{3'b110,    32'h0A0A_0A0A, 1'b0, 12'h000};
    vecs[11] = '{FLIT_HDR,  32'h1234_5FFF, 1'b1, 12'hFFF};
    vecs[12] = '{FLIT_TAIL, 32'hFFFF_FFFF, 1'b1, 12'hFFF};
    for (int i = 0; i < 13; i++) begin
      push(vecs[i].id, vecs[i].data, vecs[i].fwd, vecs[i].len);
      if (!vecs[i].fwd) exp_drops++;
    end
    drain("table");
    chk("drop_count_table", 64'(drops_seen), 64'(exp_drops));

    // Full FIFO: fifth flit refused until the first pop, including the pop cycle.
    auto_gnt = 1'b0;
    man_gnt  = 1'b0;
    push(FLIT_HDR,  32'h0BAD_0044, 1'b1, 12'h044);
    push(FLIT_BODY, 32'hB0D1_0001, 1'b1, 12'h044);
    push(FLIT_BODY, 32'hB0D1_0002, 1'b1, 12'h044);
    push(FLIT_BODY, 32'hB0D1_0003, 1'b1, 12'h044);
    @(negedge clk);
    in_valid = 1'b1;  in_flit_id = FLIT_TAIL;  in_data = 32'h5555_AAAA;
    chk("full_ready", 64'(in_ready), 64'(0));
    chk("full_head_id", 64'(flit_id), 64'(FLIT_HDR));
    chk("full_req", 64'(req), 64'(1));
    repeat (2) begin
      @(negedge clk);
      chk("full_hold_ready", 64'(in_ready), 64'(0));
      chk("full_no_out", 64'(out_valid), 64'(0));
    end
    man_gnt = 1'b1;
    @(negedge clk);
    chk("grant_cycle_ready", 64'(in_ready), 64'(0));
    @(negedge clk);
    chk("push_refused_on_pop", 64'(in_ready), 64'(1));
    sb.push_back('{FLIT_TAIL, 32'h5555_AAAA, 12'h044});
    @(posedge clk);
    #1 in_valid = 1'b0;
    drain("full");
    man_gnt = 1'b0;

    // Preemption after two forwarded flits, regrant after three cycles.
    push(FLIT_HDR,  32'h0000_0021, 1'b1, 12'h021);
    push(FLIT_BODY, 32'hC001_0001, 1'b1, 12'h021);
    push(FLIT_BODY, 32'hC001_0002, 1'b1, 12'h021);
    push(FLIT_BODY, 32'hC001_0003, 1'b1, 12'h021);
    fork
      push(FLIT_TAIL, 32'hC001_FFFF, 1'b1, 12'h021);
      begin
        @(negedge clk);
        man_gnt = 1'b1;
        repeat (3) @(negedge clk);
        man_gnt = 1'b0;
        repeat (3) begin
          @(negedge clk);
          chk("preempt_no_out", 64'(out_valid), 64'(0));
          chk("preempt_req", 64'(req), 64'(1));
        end
        man_gnt = 1'b1;
        @(negedge clk);
        chk("regrant_no_out", 64'(out_valid), 64'(0));
      end
    join
    drain("preempt");
    man_gnt = 1'b0;

    // Asynchronous reset mid-transfer.
    push(FLIT_HDR,  32'h0000_0033, 1'b1, 12'h033);
    push(FLIT_BODY, 32'hD001_0001, 1'b1, 12'h033);
    push(FLIT_BODY, 32'hD001_0002, 1'b1, 12'h033);
    push(FLIT_BODY, 32'hD001_0003, 1'b1, 12'h033);
    @(negedge clk);
    man_gnt = 1'b1;
    repeat (2) @(negedge clk);
    chk("xfer_out_valid", 64'(out_valid), 64'(1));
    chk("xfer_req", 64'(req), 64'(1));
    #2 rst = 1'b0;
    sb.delete();
    #1;
    chk("async_rst_req", 64'(req), 64'(0));
    chk("async_rst_out_valid", 64'(out_valid), 64'(0));
    chk("async_rst_ready", 64'(in_ready), 64'(1));
    chk("async_rst_flit_id", 64'(flit_id), 64'(FLIT_NONE));
    chk("async_rst_length", 64'(length), 64'(0));
    chk("async_rst_out_data", 64'(out_data), 64'(0));
    man_gnt = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("post_rst_req", 64'(req), 64'(0));
    chk("post_rst_empty", 64'(flit_id), 64'(FLIT_NONE));
    chk("post_rst_ready", 64'(in_ready), 64'(1));
    chk("post_rst_out_valid", 64'(out_valid), 64'(0));

    // Back-to-back minimal packets to wrap the pointers several times.
    auto_gnt   = 1'b1;
    fwd_before = fwd_seen;
    for (int i = 0; i < 2 * DEPTH + 1; i++) begin
      d = $urandom();
      push(FLIT_HDR, d, 1'b1, d[11:0]);
      push(FLIT_TAIL, $urandom(), 1'b1, d[11:0]);
    end
    drain("wrap");
    chk("wrap_flit_count", 64'(fwd_seen - fwd_before), 64'(2 * (2 * DEPTH + 1)));
    chk("drop_count_final", 64'(drops_seen), 64'(exp_drops));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
